// File: rtl/stream_demux2_pkg.sv
// stream_demux2_pkg: shared FSM encoding and counter width for the stream demux.
package stream_pkg;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ROUTE0 = 2'd1;
  localparam logic [1:0] ST_ROUTE1 = 2'd2;
  localparam int PKT_CNT_W = 8;
  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    ROUTE0 = ST_ROUTE0,
    ROUTE1 = ST_ROUTE1
  } state_e;
endpackage

// File: rtl/stream_demux2_if.sv
// stream_demux2_if: single valid/ready input stream plus two output streams.
interface stream_demux2_if #(parameter int WIDTH = 4);
  logic [WIDTH-1:0] d;
  logic             last;
  logic             s;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] y0;
  logic [WIDTH-1:0] y1;
  logic             y0_last;
  logic             y1_last;
  logic             y0_valid;
  logic             y1_valid;
  logic             y0_ready;
  logic             y1_ready;
  modport master (
    output d, last, s, in_valid, y0_ready, y1_ready,
    input  in_ready, y0, y1, y0_last, y1_last, y0_valid, y1_valid
  );
  modport slave (
    input  d, last, s, in_valid, y0_ready, y1_ready,
    output in_ready, y0, y1, y0_last, y1_last, y0_valid, y1_valid
  );
endinterface

// File: rtl/stream_demux2_reg_slice.sv
// stream_reg_slice: one-entry EMPTY/FULL output register that can drain and refill in one cycle.
module stream_reg_slice #(parameter int W = 5) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic         valid_q;
  logic [W-1:0] data_q;
  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (in_valid && in_ready) begin
      valid_q <= 1'b1;
      data_q  <= in_data;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end
endmodule

// File: rtl/stream_demux2.sv
// stream_demux2: registered 1:2 packet demux, route sampled on first beat and held to last.
// Define STREAM_DEMUX2_CNT_EN to add per-port packet counters pkt_cnt0/pkt_cnt1.
module stream_demux2
  import stream_pkg::*;
#(parameter int WIDTH = 4) (
  input logic clk,
  input logic reset_n,
  stream_demux2_if.slave bus
`ifdef STREAM_DEMUX2_CNT_EN
  ,
  output logic [PKT_CNT_W-1:0] pkt_cnt0,
  output logic [PKT_CNT_W-1:0] pkt_cnt1
`endif
);
  state_e         state_q, state_d;
  logic           route;
  logic           rdy0, rdy1;
  logic           acc;
  logic [WIDTH:0] o0, o1;
  // s only matters on a packet's first beat; afterwards the held route wins
  assign route        = (state_q == IDLE) ? bus.s : (state_q == ROUTE1);
  assign bus.in_ready = route ? rdy1 : rdy0;
  assign acc          = bus.in_valid && bus.in_ready;
  always_comb begin
    state_d = state_q;
    state_d = !acc ? state_q : bus.last ? IDLE : route ? ROUTE1 : ROUTE0;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end
  stream_reg_slice #(.W(WIDTH + 1)) u_slice0 (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (bus.in_valid && !route),
    .in_ready  (rdy0),
    .in_data   ({bus.last, bus.d}),
    .out_valid (bus.y0_valid),
    .out_ready (bus.y0_ready),
    .out_data  (o0)
  );
  stream_reg_slice #(.W(WIDTH + 1)) u_slice1 (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (bus.in_valid && route),
    .in_ready  (rdy1),
    .in_data   ({bus.last, bus.d}),
    .out_valid (bus.y1_valid),
    .out_ready (bus.y1_ready),
    .out_data  (o1)
  );
  assign {bus.y0_last, bus.y0} = o0;
  assign {bus.y1_last, bus.y1} = o1;
`ifdef STREAM_DEMUX2_CNT_EN
  logic [PKT_CNT_W-1:0] cnt0_q, cnt1_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (acc && bus.last) begin
      if (route) cnt1_q <= cnt1_q + 1'b1;
      else       cnt0_q <= cnt0_q + 1'b1;
    end
  end
  assign pkt_cnt0 = cnt0_q;
  assign pkt_cnt1 = cnt1_q;
`endif
endmodule

// File: tb/tb_stream_demux2.sv
// tb_stream_demux2: scoreboard bench; stimulus pushes expected beats per port, monitor pops on each output transfer.
module tb_stream_demux2;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   errs = 0;
  int   checks = 0;
  int   cyc = 0;
  logic [4:0] q0[$];
  logic [4:0] q1[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  stream_demux2_if #(.WIDTH(4)) bus ();
`ifdef STREAM_DEMUX2_CNT_EN
  logic [7:0] pkt_cnt0, pkt_cnt1;
`endif
  stream_demux2 #(.WIDTH(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
`ifdef STREAM_DEMUX2_CNT_EN
    ,
    .pkt_cnt0(pkt_cnt0),
    .pkt_cnt1(pkt_cnt1)
`endif
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) if (reset_n) begin
    if (bus.y0_valid && bus.y0_ready) begin
      if (q0.size() == 0) begin
        checks++; errs++;
        $display("FAIL y0_unexpected: got %0h expected none", {bus.y0_last, bus.y0});
      end else chk("y0_beat", {bus.y0_last, bus.y0}, q0.pop_front());
    end
    if (bus.y1_valid && bus.y1_ready) begin
      if (q1.size() == 0) begin
        checks++; errs++;
        $display("FAIL y1_unexpected: got %0h expected none", {bus.y1_last, bus.y1});
      end else chk("y1_beat", {bus.y1_last, bus.y1}, q1.pop_front());
    end
  end
  // Presents one beat, waits (bounded) for acceptance, records where it must appear.
  task automatic send(input logic [3:0] dd, input logic ll, input logic ss, input logic port);
    logic ok;
    ok = 1'b0;
    bus.d = dd; bus.last = ll; bus.s = ss; bus.in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("send_accept", ok, 1);
    if (ok) begin
      if (port) q1.push_back({ll, dd});
      else      q0.push_back({ll, dd});
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
  endtask
  task automatic drain();
    for (int i = 0; i < 20 && (q0.size() != 0 || q1.size() != 0); i++) @(posedge clk);
    #1;
    chk("drain_q0", q0.size(), 0);
    chk("drain_q1", q1.size(), 0);
  endtask
  int c0;
  initial begin
    bus.d = '0; bus.last = 1'b0; bus.s = 1'b0; bus.in_valid = 1'b0;
    bus.y0_ready = 1'b0; bus.y1_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_y0_valid", bus.y0_valid, 0);
    chk("rst_y1_valid", bus.y1_valid, 0);
    chk("rst_y0", {bus.y0_last, bus.y0}, 0);
    chk("rst_y1", {bus.y1_last, bus.y1}, 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    // mid-packet reset: held first beat must vanish and FSM must return to IDLE
    send(4'h7, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("mid_y0_held", bus.y0_valid, 1);
    q0.delete();
    reset_n = 1'b0;
    #1;
    chk("mid_rst_y0_valid", bus.y0_valid, 0);
    chk("mid_rst_y1_valid", bus.y1_valid, 0);
    @(negedge clk);
    reset_n = 1'b1;
    bus.y0_ready = 1'b1; bus.y1_ready = 1'b1;
    @(negedge clk);
    chk("mid_rel_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    send(4'h9, 1'b1, 1'b1, 1'b1);
    drain();
    // single-beat packet to port 0
    send(4'b1010, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("t2_y0_valid", bus.y0_valid, 1);
    chk("t2_y0", bus.y0, 4'b1010);
    chk("t2_y1_valid", bus.y1_valid, 0);
    drain();
    // s toggles mid-packet but the route stays on port 1
    send(4'h1, 1'b0, 1'b1, 1'b1);
    send(4'h2, 1'b0, 1'b0, 1'b1);
    send(4'h3, 1'b1, 1'b0, 1'b1);
    drain();
    // back-pressure on port 0
    bus.y0_ready = 1'b0;
    send(4'hA, 1'b1, 1'b0, 1'b0);
    bus.d = 4'hB; bus.last = 1'b1; bus.s = 1'b0; bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_in_ready", bus.in_ready, 0);
      chk("t4_y0_hold", {bus.y0_valid, bus.y0_last, bus.y0}, 6'h3A);
    end
    @(posedge clk); #1;
    bus.y0_ready = 1'b1;
    send(4'hB, 1'b1, 1'b0, 1'b0);
    drain();
    // alternating ports at full rate: six beats in six cycles
    c0 = cyc;
    for (int i = 0; i < 6; i++)
      if (i % 2 == 0) send(4'b1010, 1'b1, 1'b0, 1'b0);
      else            send(4'b0101, 1'b1, 1'b1, 1'b1);
    chk("t5_cycles", cyc - c0, 6);
    drain();
`ifdef STREAM_DEMUX2_CNT_EN
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("cnt_rst0", pkt_cnt0, 0);
    chk("cnt_rst1", pkt_cnt1, 0);
    for (int i = 0; i < 255; i++) send(4'(i), 1'b1, 1'b1, 1'b1);
    chk("cnt1_255", pkt_cnt1, 8'hFF);
    send(4'hF, 1'b1, 1'b1, 1'b1);
    chk("cnt1_wrap", pkt_cnt1, 8'h00);
    chk("cnt0_zero", pkt_cnt0, 8'h00);
    drain();
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
